// File: rtl/cdc_pulse_stretch_tx_pkg.sv
// cdc_pulse_stretch_tx_pkg
//   Shared definitions for the pulse stretcher that feeds the 2-FF
//   synchronizer bank:
//     - per-channel FSM state encoding (IDLE / HOLD / GAP)
//     - CNT_W: hold/gap counter width (covers counts up to 255)
//     - popcount32: number of set bits, used to sum simultaneous drops
//     - PSTX_RANGE_CHECK: elaboration-time parameter range check macro
//   Optional build macro: PULSE_STRETCH_DROP_CNT_EN (used by the top level).

`ifndef PSTX_RANGE_CHECK
`define PSTX_RANGE_CHECK(LBL, VAL, LO, HI) \
    if (((VAL) < (LO)) || ((VAL) > (HI))) begin : LBL \
        $error("cdc_pulse_stretch_tx: parameter out of range"); \
    end
`endif

package cdc_pulse_stretch_tx_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/cdc_pulse_stretch_tx_chan.sv
// cdc_pulse_stretch_chan
//   One channel of the pulse stretcher: IDLE -> HOLD -> GAP FSM with a
//   down-counter, a depth-1 pending-event flag and a drop strobe.
//   Ports:
//     clk, rst   source clock, async active-high reset
//     pulse_in   one-cycle event strobe
//     level_out  registered stretched level (high only in HOLD)
//     busy       registered: channel not IDLE or an event is pending
//     drop       combinational strobe: this cycle's event was lost

module cdc_pulse_stretch_chan
    import cdc_pulse_stretch_tx_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    output logic level_out,
    output logic busy,
    output logic drop
);

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic               level_q, level_d;
    logic               busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        drop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pulse_in) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (pulse_in) begin
                    if (pend_q) drop   = 1'b1;
                    else        pend_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (pulse_in && pend_q) drop = 1'b1;
                if (cnt_q == '0) begin
                    // An event landing on the last gap cycle counts as
                    // pending, so HOLD restarts with no IDLE bubble.
                    if (pend_q || pulse_in) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LD;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (pulse_in && !pend_q) pend_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
        // Outputs registered from next-state so they align with state_q.
        level_d = (state_d == ST_HOLD);
        busy_d  = (state_d != ST_IDLE) || pend_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            level_q <= level_d;
            busy_q  <= busy_d;
        end
    end

    assign level_out = level_q;
    assign busy      = busy_q;

endmodule

// File: rtl/cdc_pulse_stretch_tx.sv
// cdc_pulse_stretch_tx
//   Source-domain pulse stretcher ahead of the per-bit 2-FF synchronizer
//   bank. Each one-cycle event becomes a HOLD_CYCLES-wide high level
//   followed by at least GAP_CYCLES low; one extra event per channel is
//   queued, further events are dropped and flagged.
//   Ports:
//     clk, rst     source clock, async active-high reset
//     pulse_in     [WIDTH] per-channel event strobes
//     clear_err    one-cycle clear of err_sticky / drop_count
//     level_out    [WIDTH] registered levels to the synchronizer bank
//     busy         [WIDTH] channel active or holding a pending event
//     err_sticky   [WIDTH] sticky "an event was dropped" flags
//     drop_count   [32] saturating total of dropped events when built
//                  with PULSE_STRETCH_DROP_CNT_EN, otherwise tied to 0

module cdc_pulse_stretch_tx
    import cdc_pulse_stretch_tx_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  pulse_in,
    input  logic              clear_err,
    output logic [WIDTH-1:0]  level_out,
    output logic [WIDTH-1:0]  busy,
    output logic [WIDTH-1:0]  err_sticky,
    output logic [31:0]       drop_count
);

    `PSTX_RANGE_CHECK(g_chk_width, WIDTH, 1, 32)
    `PSTX_RANGE_CHECK(g_chk_hold, HOLD_CYCLES, 2, 255)
    `PSTX_RANGE_CHECK(g_chk_gap, GAP_CYCLES, 1, 255)

    logic [WIDTH-1:0] drop_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        cdc_pulse_stretch_chan #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .GAP_CYCLES  (GAP_CYCLES)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .pulse_in  (pulse_in[i]),
            .level_out (level_out[i]),
            .busy      (busy[i]),
            .drop      (drop_w[i])
        );
    end

    // A drop in the clearing cycle wins over the clear.
    logic [WIDTH-1:0] err_sticky_q, err_sticky_d;

    always_comb begin
        err_sticky_d = clear_err ? drop_w : (err_sticky_q | drop_w);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_sticky_q <= '0;
        else     err_sticky_q <= err_sticky_d;
    end

    assign err_sticky = err_sticky_q;

`ifdef PULSE_STRETCH_DROP_CNT_EN
    logic [31:0] drop_ext;
    logic [5:0]  drop_num;
    logic [32:0] drop_sum;
    logic [31:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_ext               = '0;
        drop_ext[WIDTH-1:0]    = drop_w;
        drop_num               = popcount32(drop_ext);
        drop_sum               = {1'b0, drop_count_q} + {27'd0, drop_num};
        if (clear_err)         drop_count_d = {26'd0, drop_num};
        else if (drop_sum[32]) drop_count_d = '1;
        else                   drop_count_d = drop_sum[31:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_count_q <= '0;
        else     drop_count_q <= drop_count_d;
    end

    assign drop_count = drop_count_q;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_cdc_pulse_stretch_tx.sv
module tb_cdc_pulse_stretch_tx;

    localparam int W    = 8;
    localparam int HOLD = 4;
    localparam int GAP  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear_err;
    logic [W-1:0]  pulse_in;
    logic [W-1:0]  level_out;
    logic [W-1:0]  busy;
    logic [W-1:0]  err_sticky;
    logic [31:0]   drop_count;

    always #5 clk = ~clk;

    cdc_pulse_stretch_tx #(
        .WIDTH       (W),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pulse_in   (pulse_in),
        .clear_err  (clear_err),
        .level_out  (level_out),
        .busy       (busy),
        .err_sticky (err_sticky),
        .drop_count (drop_count)
    );

    typedef struct {
        logic [W-1:0] lvl;
        logic [W-1:0] bsy;
        logic [W-1:0] err;
        logic [31:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference: m_t = cycles since the level rose (-1 when idle),
    // level is high while m_t < HOLD, low for the next GAP cycles.
    int           m_t[W];
    bit           m_pend[W];
    logic [W-1:0] m_err;
    logic [31:0]  m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < W; i++) begin
            m_t[i]    = -1;
            m_pend[i] = 1'b0;
        end
        m_err = '0;
        m_cnt = '0;
    endtask

    task automatic model_step(input logic [W-1:0] p, input logic clr);
        logic [W-1:0] dv;
        exp_t         e;
        longint       s;
        dv = '0;
        for (int i = 0; i < W; i++) begin
            if (m_t[i] < 0) begin
                if (p[i]) m_t[i] = 0;
            end else begin
                if (p[i]) begin
                    if (m_pend[i]) dv[i] = 1'b1;
                    else           m_pend[i] = 1'b1;
                end
                m_t[i]++;
                if (m_t[i] == HOLD + GAP) begin
                    if (m_pend[i]) begin
                        m_t[i]    = 0;
                        m_pend[i] = 1'b0;
                    end else begin
                        m_t[i] = -1;
                    end
                end
            end
        end
        m_err = clr ? dv : (m_err | dv);
`ifdef PULSE_STRETCH_DROP_CNT_EN
        s = clr ? longint'($countones(dv)) : longint'(m_cnt) + longint'($countones(dv));
        m_cnt = (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
`else
        s = 0;
        m_cnt = 32'(s);
`endif
        for (int i = 0; i < W; i++) begin
            e.lvl[i] = (m_t[i] >= 0) && (m_t[i] < HOLD);
            e.bsy[i] = (m_t[i] >= 0) || m_pend[i];
        end
        e.err = m_err;
        e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    // One clock: drive, predict, advance, compare against the scoreboard.
    task automatic cyc(input logic [W-1:0] p, input logic clr = 1'b0);
        exp_t e;
        pulse_in  = p;
        clear_err = clr;
        model_step(p, clr);
        @(posedge clk);
        #1;
        pulse_in  = '0;
        clear_err = 1'b0;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("level", 32'(level_out), 32'(e.lvl));
            chk("busy", 32'(busy), 32'(e.bsy));
            chk("err", 32'(err_sticky), 32'(e.err));
            chk("drop_cnt", drop_count, e.cnt);
        end
    endtask

    logic [31:0] c0;
    logic [W-1:0] rp;

    initial begin
        rst       = 1'b1;
        pulse_in  = '0;
        clear_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", 32'(level_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_sticky), 32'd0);
        chk("rst_cnt", drop_count, 32'd0);
        rst = 1'b0;

        // single event on ch0
        repeat (3) cyc('0);
        cyc(8'h01);
        chk("single_hi", 32'(level_out), 32'h01);
        repeat (3) cyc('0);
        chk("single_hi4", 32'(level_out), 32'h01);
        repeat (4) cyc('0);
        chk("single_gap_busy", 32'(busy), 32'h01);
        cyc('0);
        chk("single_idle", 32'(busy), 32'h00);
        repeat (2) cyc('0);

        // back-to-back on ch2: second event queued, no error
        cyc(8'h04);
        cyc('0);
        cyc(8'h04);
        repeat (14) cyc('0);
        chk("b2b_err2", 32'(err_sticky[2]), 32'd0);
        repeat (2) cyc('0);

        // overflow on ch3: third event dropped, then clear
        cyc(8'h08);
        cyc('0);
        cyc(8'h08);
        cyc(8'h08);
        repeat (5) cyc('0);
        chk("ovf_err3", 32'(err_sticky[3]), 32'd1);
`ifdef PULSE_STRETCH_DROP_CNT_EN
        chk("ovf_cnt", drop_count, 32'd1);
`else
        chk("ovf_cnt", drop_count, 32'd0);
`endif
        cyc('0, 1'b1);
        chk("clr_err", 32'(err_sticky), 32'd0);
        chk("clr_cnt", drop_count, 32'd0);
        repeat (10) cyc('0);

        // simultaneous drops on channels 0, 1, 7
        cyc(8'h83);
        cyc('0);
        cyc(8'h83);
        c0 = drop_count;
        cyc(8'h83);
`ifdef PULSE_STRETCH_DROP_CNT_EN
        chk("simul_delta", drop_count - c0, 32'd3);
`else
        chk("simul_delta", drop_count - c0, 32'd0);
`endif
        chk("simul_err", 32'(err_sticky), 32'h83);
        repeat (14) cyc('0);
        // clear + drop in the same cycle: drop wins
        cyc(8'h10);
        cyc('0);
        cyc(8'h10);
        cyc(8'h10, 1'b1);
        chk("clr_vs_drop", 32'(err_sticky), 32'h10);
        repeat (12) cyc('0, 1'b1);

        // ch1 event on the last GAP cycle: straight back to HOLD
        cyc(8'h02);
        repeat (7) cyc('0);
        cyc(8'h02);
        chk("gapx_level", 32'(level_out[1]), 32'd1);
        chk("gapx_err", 32'(err_sticky[1]), 32'd0);
        repeat (12) cyc('0);

        // async reset mid-HOLD with ch0 pending and a ch5 error flagged
        cyc(8'h21);
        cyc('0);
        cyc(8'h21);
        cyc(8'h20);
        cyc('0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_level", 32'(level_out), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_err", 32'(err_sticky), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) cyc('0);

        // sparse random traffic with occasional clears
        repeat (400) begin
            rp = '0;
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(5) == 0) rp[i] = 1'b1;
            end
            cyc(rp, ($urandom_range(19) == 0));
        end
        repeat (10) cyc('0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdc_pulse_stretch_tx.md
Name: cdc_pulse_stretch_tx

Overview:
Source-domain companion to the per-bit 2-FF synchronizer bank. It converts single-cycle event pulses on WIDTH independent channels into level pulses. Each level high is held long enough to be captured by a 2-FF synchronizer in a slower or unrelated destination clock. Each high is followed by a guaranteed low gap, so back-to-back events stay distinguishable at the far end. The block sits immediately upstream of the synchronizer bank; level_out[i] drives the synchronizer's input bit i.

Parameters:
WIDTH, 8, number of independent channels (1-32)
HOLD_CYCLES, 4, clk cycles level_out stays high per event (2-255)
GAP_CYCLES, 4, clk cycles level_out is forced low after each hold (1-255)

Ports:
clk  input  1  single source clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
pulse_in  input  WIDTH  per-channel event strobe, one cycle high = one event
clear_err  input  1  synchronous one-cycle clear of err_sticky (and drop_count when compiled in)
level_out  output  WIDTH  registered stretched level to the synchronizer bank
busy  output  WIDTH  channel in HOLD or GAP, or has a pending event
err_sticky  output  WIDTH  per-channel sticky flag: at least one event dropped
drop_count  output  32  total dropped events, all channels (see Optional Feature)

Behaviour:
- Reset (async assert, released synchronously to clk externally):
  - every channel state = IDLE, counters = 0, pending = 0
  - level_out = 0, busy = 0, err_sticky = 0, drop_count = 0
- Per-channel FSM, with states IDLE, HOLD, GAP:
  - IDLE: pulse_in high → HOLD; counter loads HOLD_CYCLES-1.
  - HOLD: level_out = 1. Counter decrements; at 0 → GAP, counter loads GAP_CYCLES-1.
  - GAP: level_out = 0. Counter decrements; at 0 → HOLD if pending (clear pending, reload hold), else → IDLE.
- Latency: pulse_in at edge n → level_out high from edge n+1 for exactly HOLD_CYCLES cycles, then low for at least GAP_CYCLES cycles.
- level_out is driven directly from a flop (state==HOLD registered). There is no combinational path from pulse_in, so the synchronizer source is glitch-free.
- Event arrival in HOLD or GAP:
  - pending = 0 → set pending (queue depth 1).
  - pending = 1 → event dropped; set err_sticky[i].
- pulse_in high in the same cycle GAP expires with pending = 0: treated as pending, so HOLD follows directly; no IDLE cycle and no drop.
- pulse_in held high for k cycles counts as k events. The bench exercises this as a drop case.
- busy[i] = (state != IDLE) | pending, registered in step with level_out.
- clear_err in the same cycle as a new drop: the drop wins; err_sticky stays/sets to 1 and the count increments from 0.
- Channels are fully independent; no shared arbitration.
- Asynchronous rst mid-HOLD drops level_out to 0 immediately; pending events are discarded.

Optional Feature:
- Macro: PULSE_STRETCH_DROP_CNT_EN
- Defined:
  - drop_count is a 32-bit saturating counter (sticks at 0xFFFF_FFFF).
  - It increments by the number of channels dropping in that cycle; multiple simultaneous drops are summed via a popcount.
  - clear_err zeroes it.
- Undefined:
  - drop_count is tied to 0; no counter or popcount logic is synthesized.
  - err_sticky still functions.

Decomposition:
- Shared package/header holds:
  - state encoding constants: ST_IDLE=2'd0, ST_HOLD=2'd1, ST_GAP=2'd2
  - counter width constant CNT_W = 8 (covers 255)
  - parameter range-check macro
- One natural sub-module, cdc_pulse_stretch_chan: FSM, counter, pending flag and drop strobe for a single channel, instantiated WIDTH times in a generate loop.
- The top level owns err_sticky aggregation, the popcount and drop_count.

Test Plan:
- Single event: ch0 pulse_in high 1 cycle at edge 10 → level_out[0] high at edges 11-14, low at 15-18, busy[0] low at edge 19; other channels stay 0.
- Back-to-back: ch2 pulses at edges 10 and 12 → level_out[2] high 11-14, low 15-18, high 19-22; err_sticky[2]=0.
- Overflow: ch3 pulses at edges 10, 12, 13 → third event dropped; err_sticky[3]=1; drop_count=1 (macro on) / 0 (macro off); clear_err at edge 30 → both 0.
- Simultaneous drops: channels 0, 1 and 7 each drop one event on the same cycle → drop_count increments by 3 in one cycle.
- GAP-expiry edge case: ch1 pulse arrives exactly on the last GAP cycle → HOLD resumes the next cycle with no IDLE cycle and no drop.
- Reset mid-operation: assert rst during HOLD with pending=1 → level_out, busy and err_sticky are 0 asynchronously; after release, no stale HOLD occurs.
